// File: rtl/gpr_write_demux.sv
// MIPS general-purpose register file built around a 1-to-32 write-address decoder.
// Two combinational read ports, optional same-cycle write bypass, and a registered write-strobe record.
module gpr_write_demux #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [ADDR_W-1:0]        raddr1,
  output logic [DATA_W-1:0]        rdata1,
  input  logic [ADDR_W-1:0]        raddr2,
  output logic [DATA_W-1:0]        rdata2,
  output logic [(1<<ADDR_W)-1:0]   wsel,
  output logic [(1<<ADDR_W)-1:0]   last_wsel,
  output logic [15:0]              wr_count
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] r_regs [NREG];
  logic [NREG-1:0]   r_last_wsel;
  logic [15:0]       r_wr_count;
  logic              w_commit;

  // Write decoder. Bit 0 is never set, so register 0 can never be written.
  // An unknown waddr with we=0 still yields an all-zero select.
  always_comb begin
    // NOTE: assign a default before the loop so every bit is driven on every path; otherwise a latch is inferred.
    wsel = '0;
    for (int i = 1; i < NREG; i++) begin
      wsel[i] = we && (waddr == ADDR_W'(i));
    end
  end

  assign w_commit = |wsel;

  // Register array: only the decoded entry loads; entry 0 stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: this array is reset because the architecture requires zeroed registers; a plain RAM would skip the reset.
    // State is updated with non-blocking assignments so all flops sample the same pre-edge values.
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (wsel[i]) begin
          r_regs[i] <= wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_wsel <= '0;
      r_wr_count  <= '0;
    end else begin
      r_last_wsel <= wsel;
      if (w_commit) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

  assign last_wsel = r_last_wsel;
  assign wr_count  = r_wr_count;

  // Read ports: zero is returned for address 0 and throughout reset. Bypass is applied otherwise.
  always_comb begin
    rdata1 = r_regs[raddr1];
    if (!rst_n || raddr1 == '0) begin
      rdata1 = '0;
    end else if (BYPASS && wsel[raddr1]) begin
      rdata1 = wdata;
    end
  end

  always_comb begin
    rdata2 = r_regs[raddr2];
    if (!rst_n || raddr2 == '0) begin
      rdata2 = '0;
    end else if (BYPASS && wsel[raddr2]) begin
      rdata2 = wdata;
    end
  end

  a_wsel_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(wsel));

endmodule

// File: tb/tb_gpr_write_demux.sv
// Randomised self-checking bench for gpr_write_demux. Bypass and non-bypass instances share
// their inputs and are compared against an array-based register-file model.
module tb_gpr_write_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [4:0]  raddr1 = '0;
  logic [4:0]  raddr2 = '0;

  logic [31:0] rdata1_b, rdata2_b, wsel_b, last_wsel_b;
  logic [31:0] rdata1_n, rdata2_n, wsel_n, last_wsel_n;
  logic [15:0] wr_count_b, wr_count_n;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain array of register values plus a commit counter.
  logic [31:0] model [32];
  int          model_count;
  logic [31:0] exp_last_wsel;

  gpr_write_demux #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rdata1_b), .raddr2(raddr2), .rdata2(rdata2_b),
    .wsel(wsel_b), .last_wsel(last_wsel_b), .wr_count(wr_count_b)
  );

  gpr_write_demux #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u_nobyp (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .rdata1(rdata1_n), .raddr2(raddr2), .rdata2(rdata2_n),
    .wsel(wsel_n), .last_wsel(last_wsel_n), .wr_count(wr_count_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_wsel();
    if (we === 1'b1 && waddr != 0) return 32'd1 << waddr;
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit bypass);
    if (a == 0) return 32'd0;
    if (bypass && we === 1'b1 && waddr == a) return wdata;
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model_count   = 0;
    exp_last_wsel = 32'd0;
  endtask

  // One clock cycle. Entered and left at posedge+1. Combinational outputs are
  // checked at the negedge, and registered outputs just after the next posedge.
  task automatic step(input logic we_i, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2, input bit chk);
    we = we_i; waddr = wa; wdata = wd; raddr1 = r1; raddr2 = r2;
    @(negedge clk);
    if (chk) begin
      check("rdata1_byp",   rdata1_b, exp_read(r1, 1'b1));
      check("rdata2_byp",   rdata2_b, exp_read(r2, 1'b1));
      check("rdata1_nobyp", rdata1_n, exp_read(r1, 1'b0));
      check("rdata2_nobyp", rdata2_n, exp_read(r2, 1'b0));
      check("wsel_byp",     wsel_b,   exp_wsel());
      check("wsel_nobyp",   wsel_n,   exp_wsel());
    end
    exp_last_wsel = exp_wsel();
    @(posedge clk);
    #1;
    if (we_i === 1'b1 && wa != 0) begin
      model[wa]   = wd;
      model_count = model_count + 1;
    end
    if (chk) begin
      check("last_wsel_byp",   last_wsel_b, exp_last_wsel);
      check("last_wsel_nobyp", last_wsel_n, exp_last_wsel);
      check("wr_count_byp",    {16'd0, wr_count_b}, 32'(model_count % 65536));
      check("wr_count_nobyp",  {16'd0, wr_count_n}, 32'(model_count % 65536));
    end
  endtask

  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state
    check("reset_wr_count",  {16'd0, wr_count_b}, 32'd0);
    check("reset_last_wsel", last_wsel_b, 32'd0);
    step(1'b0, 5'd0, 32'd0, 5'd1, 5'd31, 1'b1);

    // Basic write/read
    step(1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0, 1'b1);
    check("basic_last_wsel", last_wsel_b, 32'h00000080);
    step(1'b0, 5'd0, 32'd0, 5'd7, 5'd8, 1'b1);
    check("basic_rdata1", rdata1_b, 32'h12345678);
    check("basic_count",  {16'd0, wr_count_b}, 32'd1);

    // Zero register: ignored write, no count
    step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1);

    // Bypass scenario: reg3=A, then write B with both ports on reg3
    step(1'b1, 5'd3, 32'h0000000A, 5'd1, 5'd2, 1'b1);
    step(1'b1, 5'd3, 32'h0000000B, 5'd3, 5'd3, 1'b1);
    step(1'b0, 5'd0, 32'd0, 5'd3, 5'd3, 1'b1);

    // Unknown write address with we=0 must not change state
    step(1'b0, 5'bxxxxx, 32'hCAFEF00D, 5'd3, 5'd7, 1'b1);

    // Asynchronous reset mid-cycle after writing reg5
    step(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1);
    #2;
    rst_n = 1'b0;
    we = 1'b1; waddr = 5'd5; wdata = 32'h11111111; raddr1 = 5'd5; raddr2 = 5'd5;
    #1;
    check("rst_rdata1_byp",   rdata1_b, 32'd0);
    check("rst_rdata2_nobyp", rdata2_n, 32'd0);
    check("rst_last_wsel",    last_wsel_b, 32'd0);
    check("rst_wr_count",     {16'd0, wr_count_b}, 32'd0);
    @(posedge clk);
    #1;
    check("rst_hold_rdata1", rdata1_b, 32'd0);
    check("rst_hold_count",  {16'd0, wr_count_n}, 32'd0);
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
    step(1'b0, 5'd0, 32'd0, 5'd5, 5'd7, 1'b1);

    // Decoder sweep from a clean reset state
    for (int n = 1; n < 32; n++) begin
      step(1'b1, 5'(n), 32'(n) * 32'h01010101, 5'(n), 5'(n - 1), 1'b1);
    end
    check("sweep_count", {16'd0, wr_count_b}, 32'd31);
    for (int n = 0; n < 32; n++) begin
      step(1'b0, 5'd0, 32'd0, 5'(n), 5'(31 - n), 1'b1);
    end

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      logic        rwe;
      logic [4:0]  wa, r1, r2;
      rwe = ($urandom_range(0, 3) != 0);
      wa  = 5'($urandom_range(0, 31));
      r1  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      r2  = ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31));
      step(rwe, wa, $urandom, r1, r2, 1'b1);
    end

    // Counter wrap: 65536 commits that rewrite existing values
    for (int k = 0; k < 65536; k++) begin
      logic [4:0] wa;
      wa = 5'((k % 31) + 1);
      step(1'b1, wa, model[wa], 5'd0, 5'd0, 1'b0);
    end
    check("wrap_count_byp",   {16'd0, wr_count_b}, 32'(model_count % 65536));
    check("wrap_count_nobyp", {16'd0, wr_count_n}, 32'(model_count % 65536));
    for (int n = 0; n < 32; n++) begin
      step(1'b0, 5'd0, 32'd0, 5'(n), 5'(n ^ 1), 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpr_write_demux.md
Name: gpr_write_demux

Overview:
- MIPS general-purpose register file, organised around a 1-to-32 write-address demultiplexer (decoder) that routes one write-back datum to exactly one of 32 registers.
- It is the fan-out counterpart of the datapath's select-multiplexers.
- It sits between the write-back stage (writer) and the decode stage (two combinational read ports).
- It provides optional write-to-read bypass and a registered write-strobe record for debug and verification.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; register count = 2**ADDR_W.
- BYPASS, 1, 1 = same-cycle write data forwarded to a read port addressing the written register; 0 = read returns the stored value only.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- we  input  1  write enable from write-back stage.
- waddr  input  ADDR_W  destination register number.
- wdata  input  DATA_W  write-back data.
- raddr1  input  ADDR_W  read port 1 register number (rs).
- rdata1  output  DATA_W  read port 1 data.
- raddr2  input  ADDR_W  read port 2 register number (rt).
- rdata2  output  DATA_W  read port 2 data.
- wsel  output  2**ADDR_W  combinational one-hot write-select: bit waddr set when we=1 and waddr!=0, else all zero.
- last_wsel  output  2**ADDR_W  wsel captured on the last clock edge (registered).
- wr_count  output  16  count of committed writes since reset.

Behaviour:
- Reset (rst_n=0, asynchronous): registers 1..31 clear to 0; last_wsel=0; wr_count=0. rdata1/rdata2 therefore read 0 for any address while in reset (bypass is suppressed during reset). The reset takes effect immediately, mid-write included; a write coinciding with the rst_n release edge is discarded.
- Register 0 is hard-wired to 0: writes with waddr=0 are ignored, produce wsel=0 and do not increment wr_count. Reads of address 0 always return 0, including under bypass.
- Write commit: on the rising clk edge with we=1 and waddr!=0, reg[waddr] <= wdata. Only the decoded register changes; all others hold.
- wsel is purely combinational from we and waddr. At most one bit is ever set.
- last_wsel <= wsel on every rising edge.
- wr_count increments by 1 on each committed write. It wraps from 16'hFFFF to 0 and does not saturate.
- Read ports are combinational, with zero-cycle latency from raddr to rdata.
- With BYPASS=1: if we=1, waddr!=0 and raddrN==waddr, then rdataN = wdata in the same cycle. Otherwise rdataN = reg[raddrN].
- With BYPASS=0: rdataN = reg[raddrN]. The new value becomes visible the cycle after the commit edge.
- Both read ports may address the same register, or the register being written, simultaneously. Each port resolves independently per the rules above.
- No X propagation: an unknown waddr while we=0 must not alter any register.

Test Plan:
- Reset: assert rst_n=0 mid-simulation after writing reg5=32'hDEADBEEF -> rdata1 (raddr1=5)=0 immediately (asynchronous), last_wsel=0, wr_count=0.
- Basic write/read: we=1, waddr=7, wdata=32'h12345678 for one edge; then raddr1=7, raddr2=8 -> rdata1=32'h12345678, rdata2=0, last_wsel=32'h00000080, wr_count=1.
- Zero register: we=1, waddr=0, wdata=32'hFFFFFFFF -> wsel=0, rdata1 (raddr1=0)=0, wr_count unchanged.
- Bypass: BYPASS=1, reg3=32'hA, same cycle we=1, waddr=3, wdata=32'hB, raddr1=raddr2=3 -> both rdata=32'hB before the edge. With BYPASS=0 -> 32'hA before the edge, 32'hB after.
- Decoder sweep: write reg N with value N*32'h01010101 for N=1..31, then read all -> each register holds its own value, wsel one-hot at bit N each cycle, wr_count=31.
- Counter wrap: preload or run 65536 committed writes -> wr_count returns to 0 with no side effect on register contents.
